// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter of two byte-stream requesters onto one uart_tx.
// A grant covers a whole frame, bounded by MAX_BURST bytes and HOLD_TO idle cycles.
module uart_tx_arb #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned HOLD_TO   = 1000
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [1:0] grant
);
  localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);
  localparam logic [15:0] HOLD_MAX  = 16'(HOLD_TO);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, HOLD} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;        // 1: req1 has priority in IDLE
  logic [7:0]  burst_q, burst_d;
  logic [15:0] hold_q, hold_d;
  logic        last_q, last_d;
  logic [1:0]  grant_d;
  logic        tx_start_d;
  logic [7:0]  tx_data_d;
  logic        r0_d, r1_d;
  logic        pick, own, own_valid;
  logic        go_send, rel;

  assign pick      = req1_valid & (~req0_valid | ptr_q);
  assign own       = (state_q == IDLE) ? pick : grant[1];
  assign own_valid = own ? req1_valid : req0_valid;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      burst_q    <= '0;
      hold_q     <= '0;
      last_q     <= 1'b0;
      grant      <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      grant      <= grant_d;
      tx_start   <= tx_start_d;
      tx_data    <= tx_data_d;
      req0_ready <= r0_d;
      req1_ready <= r1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    hold_d     = hold_q;
    last_d     = last_q;
    grant_d    = grant;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    r0_d       = 1'b0;
    r1_d       = 1'b0;
    go_send    = 1'b0;
    rel        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!tx_busy && (req0_valid || req1_valid)) begin
          grant_d = pick ? 2'b10 : 2'b01;
          burst_d = '0;
          go_send = 1'b1;
        end
      end
      SEND:    state_d = WAIT_HI;
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q || burst_q == BURST_MAX) begin
            rel = 1'b1;
          end else if (own_valid) begin
            go_send = 1'b1;
          end else begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
      end
      HOLD: begin
        if (own_valid) begin
          go_send = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
          if (hold_q + 16'd1 == HOLD_MAX) rel = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // SEND's outputs, last latch and burst count are registered on entry so they hold during SEND
    if (go_send) begin
      state_d    = SEND;
      tx_start_d = 1'b1;
      tx_data_d  = own ? req1_data : req0_data;
      last_d     = own ? req1_last : req0_last;
      r0_d       = ~own;
      r1_d       = own;
      burst_d    = burst_d + 8'd1;
    end

    if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = ~own;
    end
  end
endmodule
